id_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Decides the forwarding selects for the ID-stage branch comparator and for the EX-stage ALU operands.
- Sequences multi-cycle stalls, for load-use and branch-in-ID dependencies, through a registered stall counter.
- Generates the IF/ID flush for branches taken in ID.
- Keeps a free-running stall-cycle performance counter.

---
 rtl/id_hazard_if.sv | 48 ++++
 rtl/id_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_if.sv
// Hazard/forwarding bundle between the RV32I pipeline datapath and id_hazard_ctrl.
// master = pipeline side (drives stage fields), slave = controller (drives selects/stalls).
interface id_hazard_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             uses_rs1_id;
  logic             uses_rs2_id;
  logic             branch_id;
  logic             branch_taken_id;
  logic [4:0]       rs1_ex;
  logic [4:0]       rs2_ex;
  logic [4:0]       rd_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic [4:0]       rd_mem;
  logic             reg_write_mem;
  logic             mem_read_mem;
  logic [4:0]       rd_wb;
  logic             reg_write_wb;
  logic             mem_busy;
  logic [1:0]       rs1_fwd_id;
  logic [1:0]       rs2_fwd_id;
  logic [1:0]       rs1_fwd_ex;
  logic [1:0]       rs2_fwd_ex;
  logic             stall_if_id;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             freeze;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, branch_id, branch_taken_id,
           rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, reg_write_mem, mem_read_mem, rd_wb, reg_write_wb, mem_busy,
    input  rs1_fwd_id, rs2_fwd_id, rs1_fwd_ex, rs2_fwd_ex,
           stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, branch_id, branch_taken_id,
           rs1_ex, rs2_ex, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, reg_write_mem, mem_read_mem, rd_wb, reg_write_wb, mem_busy,
    output rs1_fwd_id, rs2_fwd_id, rs1_fwd_ex, rs2_fwd_ex,
           stall_if_id, bubble_id_ex, flush_if_id, freeze, stall_cycles
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: forward selects,
// multi-cycle stall sequencing, IF/ID flush and a stall-cycle performance counter.
module id_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic         clk,
  input logic         rst,
  id_hazard_if.slave  hz
);
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic {RUN, HOLD} phase_e;

  logic [1:0]       cnt_q, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  phase_e           phase;
  logic [1:0]       need1, need2, need;
  logic             stall_c, bubble_c, flush_c;
  logic [1:0]       rs1_fwd_id_c, rs2_fwd_id_c, rs1_fwd_ex_c, rs2_fwd_ex_c;

  // Producer in a later stage writes register r (x0 never matches).
  function automatic logic match(input logic [4:0] rd, input logic we, input logic [4:0] r);
    return (rd == r) && (rd != 5'd0) && we;
  endfunction

  // Stall cycles demanded by one ID source operand.
  function automatic logic [1:0] src_need(
    input logic used, input logic br, input logic m_ex, input logic ld_ex,
    input logic m_mem, input logic ld_mem
  );
    logic [1:0] n;
    n = 2'd0;
    if (used) begin
      if (m_ex && ld_ex)       n = br ? 2'd2 : 2'd1;
      else if (m_ex && br)     n = 2'd1;
      else if (br && m_mem && ld_mem) n = 2'd1;
    end
    return n;
  endfunction

  function automatic logic [1:0] ex_sel(
    input logic m_mem, input logic ld_mem, input logic m_wb
  );
    if (m_mem && !ld_mem) return FWD_MEM;
    if (m_wb)             return FWD_WB;
    return FWD_NONE;
  endfunction

  always_comb begin
    need1 = src_need(hz.uses_rs1_id, hz.branch_id,
                     match(hz.rd_ex, hz.reg_write_ex, hz.rs1_id), hz.mem_read_ex,
                     match(hz.rd_mem, hz.reg_write_mem, hz.rs1_id), hz.mem_read_mem);
    need2 = src_need(hz.uses_rs2_id, hz.branch_id,
                     match(hz.rd_ex, hz.reg_write_ex, hz.rs2_id), hz.mem_read_ex,
                     match(hz.rd_mem, hz.reg_write_mem, hz.rs2_id), hz.mem_read_mem);
    need  = (need1 > need2) ? need1 : need2;
  end

  always_comb begin
    rs1_fwd_id_c = (hz.branch_id && hz.uses_rs1_id && !hz.mem_read_mem &&
                    match(hz.rd_mem, hz.reg_write_mem, hz.rs1_id)) ? FWD_MEM : FWD_NONE;
    rs2_fwd_id_c = (hz.branch_id && hz.uses_rs2_id && !hz.mem_read_mem &&
                    match(hz.rd_mem, hz.reg_write_mem, hz.rs2_id)) ? FWD_MEM : FWD_NONE;
    rs1_fwd_ex_c = ex_sel(match(hz.rd_mem, hz.reg_write_mem, hz.rs1_ex), hz.mem_read_mem,
                          match(hz.rd_wb, hz.reg_write_wb, hz.rs1_ex));
    rs2_fwd_ex_c = ex_sel(match(hz.rd_mem, hz.reg_write_mem, hz.rs2_ex), hz.mem_read_mem,
                          match(hz.rd_wb, hz.reg_write_wb, hz.rs2_ex));
  end

  assign phase = (cnt_q == 2'd0) ? RUN : HOLD;

  // Stall FSM next-state; HOLD ignores new hazards, mem_busy freezes the counter.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    cnt_nxt  = cnt_q;
    case (phase)
      RUN: begin
        if (need != 2'd0) begin
          stall_c = 1'b1;
          cnt_nxt = need - 2'd1;
        end
      end
      HOLD: begin
        stall_c = 1'b1;
        cnt_nxt = cnt_q - 2'd1;
      end
      default: cnt_nxt = 2'd0;
    endcase
    if (hz.mem_busy) cnt_nxt = cnt_q;
    bubble_c = stall_c && !hz.mem_busy;
    flush_c  = hz.branch_taken_id && !stall_c && !hz.mem_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_cnt_q <= '0;
    else if (stall_c && !hz.mem_busy)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  // Reset forces every output low immediately.
  assign hz.rs1_fwd_id   = rst ? FWD_NONE : rs1_fwd_id_c;
  assign hz.rs2_fwd_id   = rst ? FWD_NONE : rs2_fwd_id_c;
  assign hz.rs1_fwd_ex   = rst ? FWD_NONE : rs1_fwd_ex_c;
  assign hz.rs2_fwd_ex   = rst ? FWD_NONE : rs2_fwd_ex_c;
  assign hz.stall_if_id  = stall_c  && !rst;
  assign hz.bubble_id_ex = bubble_c && !rst;
  assign hz.flush_if_id  = flush_c  && !rst;
  assign hz.freeze       = hz.mem_busy && !rst;
  assign hz.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: forwarding, stall sequencing, flush/freeze and reset.
module tb_id_hazard_ctrl;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  id_hazard_if #(.CNT_W(CNT_W)) hif ();

  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    hif.rs1_id = 5'd0; hif.rs2_id = 5'd0; hif.uses_rs1_id = 1'b0; hif.uses_rs2_id = 1'b0;
    hif.branch_id = 1'b0; hif.branch_taken_id = 1'b0;
    hif.rs1_ex = 5'd0; hif.rs2_ex = 5'd0; hif.rd_ex = 5'd0;
    hif.reg_write_ex = 1'b0; hif.mem_read_ex = 1'b0;
    hif.rd_mem = 5'd0; hif.reg_write_mem = 1'b0; hif.mem_read_mem = 1'b0;
    hif.rd_wb = 5'd0; hif.reg_write_wb = 1'b0; hif.mem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // EX load x7 with ID branch reading x7 (needs two stall cycles).
  task automatic load_branch();
    clear();
    hif.rd_ex = 5'd7; hif.reg_write_ex = 1'b1; hif.mem_read_ex = 1'b1;
    hif.branch_id = 1'b1; hif.rs1_id = 5'd7; hif.uses_rs1_id = 1'b1; hif.uses_rs2_id = 1'b1;
  endtask

  // Same branch one cycle later: load now in MEM, bubble in EX.
  task automatic load_in_mem();
    load_branch();
    hif.rd_ex = 5'd0; hif.reg_write_ex = 1'b0; hif.mem_read_ex = 1'b0;
    hif.rd_mem = 5'd7; hif.reg_write_mem = 1'b1; hif.mem_read_mem = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    hif.mem_busy = 1'b1; hif.branch_taken_id = 1'b1;
    hif.rd_mem = 5'd9; hif.reg_write_mem = 1'b1; hif.rs1_ex = 5'd9;
    step();
    chk("rst_freeze", 32'(hif.freeze), 32'd0);
    chk("rst_flush", 32'(hif.flush_if_id), 32'd0);
    chk("rst_fwd_ex", 32'(hif.rs1_fwd_ex), 32'd0);
    chk("rst_cycles", hif.stall_cycles, 32'd0);
    clear();
    rst = 1'b0;
    settle();

    // load-use: one stall cycle
    hif.rd_ex = 5'd5; hif.reg_write_ex = 1'b1; hif.mem_read_ex = 1'b1;
    hif.rs1_id = 5'd5; hif.uses_rs1_id = 1'b1;
    settle();
    chk("lu_stall", 32'(hif.stall_if_id), 32'd1);
    chk("lu_bubble", 32'(hif.bubble_id_ex), 32'd1);
    chk("lu_cycles0", hif.stall_cycles, 32'd0);
    step();
    clear();
    hif.rs1_id = 5'd5; hif.uses_rs1_id = 1'b1;
    hif.rd_mem = 5'd5; hif.reg_write_mem = 1'b1; hif.mem_read_mem = 1'b1;
    settle();
    chk("lu_release", 32'(hif.stall_if_id), 32'd0);
    chk("lu_cycles1", hif.stall_cycles, 32'd1);
    step();
    clear();
    hif.rs1_ex = 5'd5; hif.rd_wb = 5'd5; hif.reg_write_wb = 1'b1;
    settle();
    chk("lu_fwd_wb", 32'(hif.rs1_fwd_ex), 32'd2);
    hif.rd_mem = 5'd5; hif.reg_write_mem = 1'b1; hif.mem_read_mem = 1'b1;
    settle();
    chk("lu_no_mem_load_fwd", 32'(hif.rs1_fwd_ex), 32'd2);

    // branch after load: two stall cycles
    load_branch();
    settle();
    chk("bl_stall1", 32'(hif.stall_if_id), 32'd1);
    step();
    load_in_mem();
    settle();
    chk("bl_stall2", 32'(hif.stall_if_id), 32'd1);
    chk("bl_fwd_id_load", 32'(hif.rs1_fwd_id), 32'd0);
    step();
    load_branch();
    hif.rd_ex = 5'd0; hif.reg_write_ex = 1'b0; hif.mem_read_ex = 1'b0;
    hif.rd_wb = 5'd7; hif.reg_write_wb = 1'b1;
    settle();
    chk("bl_release", 32'(hif.stall_if_id), 32'd0);
    chk("bl_fwd_id", 32'(hif.rs1_fwd_id), 32'd0);
    chk("bl_cycles", hif.stall_cycles, 32'd3);

    // branch after ALU op: one stall then ID forward from MEM
    clear();
    hif.rd_ex = 5'd3; hif.reg_write_ex = 1'b1;
    hif.branch_id = 1'b1; hif.rs1_id = 5'd3; hif.rs2_id = 5'd4;
    hif.uses_rs1_id = 1'b1; hif.uses_rs2_id = 1'b1;
    settle();
    chk("ba_stall", 32'(hif.stall_if_id), 32'd1);
    step();
    hif.rd_ex = 5'd0; hif.reg_write_ex = 1'b0;
    hif.rd_mem = 5'd3; hif.reg_write_mem = 1'b1;
    settle();
    chk("ba_release", 32'(hif.stall_if_id), 32'd0);
    chk("ba_fwd_rs1", 32'(hif.rs1_fwd_id), 32'd1);
    chk("ba_fwd_rs2", 32'(hif.rs2_fwd_id), 32'd0);
    chk("ba_cycles", hif.stall_cycles, 32'd4);

    // unused source and x0 never stall
    clear();
    hif.rd_ex = 5'd4; hif.reg_write_ex = 1'b1; hif.mem_read_ex = 1'b1; hif.rs2_id = 5'd4;
    settle();
    chk("unused_rs2", 32'(hif.stall_if_id), 32'd0);
    hif.rd_ex = 5'd0; hif.rs1_id = 5'd0; hif.uses_rs1_id = 1'b1;
    settle();
    chk("x0_stall", 32'(hif.stall_if_id), 32'd0);

    // forward priority and x0
    clear();
    hif.rd_mem = 5'd9; hif.reg_write_mem = 1'b1; hif.rd_wb = 5'd9; hif.reg_write_wb = 1'b1;
    hif.rs2_ex = 5'd9;
    settle();
    chk("fp_mem_over_wb", 32'(hif.rs2_fwd_ex), 32'd1);
    hif.rd_mem = 5'd0; hif.rs1_ex = 5'd0;
    settle();
    chk("fp_x0", 32'(hif.rs1_fwd_ex), 32'd0);
    chk("fp_wb_only", 32'(hif.rs2_fwd_ex), 32'd2);

    // flush
    clear();
    hif.branch_taken_id = 1'b1;
    settle();
    chk("fl_taken", 32'(hif.flush_if_id), 32'd1);
    hif.mem_busy = 1'b1;
    settle();
    chk("fl_busy", 32'(hif.flush_if_id), 32'd0);
    chk("fl_freeze", 32'(hif.freeze), 32'd1);
    step();
    clear();
    hif.rd_ex = 5'd3; hif.reg_write_ex = 1'b1; hif.branch_id = 1'b1;
    hif.rs1_id = 5'd3; hif.uses_rs1_id = 1'b1; hif.branch_taken_id = 1'b1;
    settle();
    chk("fl_in_stall", 32'(hif.flush_if_id), 32'd0);
    step();
    clear();
    settle();
    chk("fl_cycles", hif.stall_cycles, 32'd5);

    // mem_busy in the middle of a 2-cycle stall
    load_branch();
    settle();
    step();
    load_in_mem();
    hif.mem_busy = 1'b1;
    settle();
    chk("mb_freeze", 32'(hif.freeze), 32'd1);
    chk("mb_stall", 32'(hif.stall_if_id), 32'd1);
    chk("mb_bubble", 32'(hif.bubble_id_ex), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mb_hold_stall", 32'(hif.stall_if_id), 32'd1);
      chk("mb_hold_cycles", hif.stall_cycles, 32'd6);
    end
    hif.mem_busy = 1'b0;
    settle();
    chk("mb_resume_bubble", 32'(hif.bubble_id_ex), 32'd1);
    chk("mb_resume_freeze", 32'(hif.freeze), 32'd0);
    step();
    clear();
    settle();
    chk("mb_done", 32'(hif.stall_if_id), 32'd0);
    chk("mb_cycles", hif.stall_cycles, 32'd7);

    // asynchronous reset mid-stall
    load_branch();
    settle();
    step();
    load_in_mem();
    settle();
    chk("rs_pre_stall", 32'(hif.stall_if_id), 32'd1);
    chk("rs_pre_cycles", hif.stall_cycles, 32'd8);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_stall", 32'(hif.stall_if_id), 32'd0);
    chk("rs_async_bubble", 32'(hif.bubble_id_ex), 32'd0);
    chk("rs_async_cycles", hif.stall_cycles, 32'd0);
    step();
    clear();
    rst = 1'b0;
    settle();
    chk("rs_run_stall", 32'(hif.stall_if_id), 32'd0);
    step();
    chk("rs_run_stall2", 32'(hif.stall_if_id), 32'd0);
    chk("rs_run_cycles", hif.stall_cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
